instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the processor's 16-bit instruction memory: receives a framed byte stream, assembles 16-bit instruction words and issues sequential write strobes into the instruction RAM.
- Holds the core in reset (cpu_hold) while a program is loading.
- Sits between the host/byte-link receiver and the instruction RAM write port; the core's fetch path reads the same RAM.

Parameters:
- MAX_WORDS, 1024, largest accepted program length in words.
- BASE_ADDR, 16'h0000, address of the first written word.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load. Ignored while a load is in progress.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- wr_en  out  1  instruction RAM write strobe, one cycle per word.
- wr_addr  out  16  instruction RAM write address.
- wr_data  out  16  instruction word {hi_byte, lo_byte}.
- cpu_hold  out  1  core held in reset while 1.
- done  out  1  level; last load completed with a good checksum.
- error  out  1  level; last load was rejected.

Behaviour:
- Frame format, in order:
  - LEN_HI, LEN_LO: word count N, big-endian.
  - N word pairs, each high byte then low byte.
  - One checksum byte equal to the XOR of all preceding frame bytes, including the length bytes.
- Reset values:
  - State IDLE.
  - in_ready, wr_en, done and error = 0.
  - wr_addr = BASE_ADDR; wr_data = 0.
  - cpu_hold = 1, so the core does not run until a valid program is loaded.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- in_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. It is a registered state decode, independent of in_valid.
- Transitions (all advance only on a byte handshake unless stated):
  - IDLE/DONE/ERROR --start--> LEN_HI. This clears done, error, the checksum accumulator and the word index, and sets cpu_hold=1.
  - LEN_HI -> LEN_LO.
  - LEN_LO:
    - N > MAX_WORDS -> ERROR.
    - N == 0 -> CHECK.
    - Otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO.
  - DATA_LO: if the word index reaches N -> CHECK, else -> DATA_HI.
  - CHECK: accumulator XOR received byte == 0 -> DONE, else -> ERROR.
- Write timing:
  - wr_en pulses exactly one cycle, in the cycle after the DATA_LO handshake.
  - wr_addr = BASE_ADDR + index, with 16-bit wrap-around.
  - wr_data holds its value until the next write.
  - Word k is written before word k+1, and no write is issued for the length or checksum bytes.
- Back-to-back input is allowed: one byte per cycle sustains one write every two cycles.
- Completion flags:
  - done and cpu_hold=0 are asserted in the cycle after the good checksum byte.
  - error is asserted in the cycle after a bad checksum or an oversize length.
  - cpu_hold stays 1 on error.
  - DONE and ERROR are sticky until start or reset.
- Words already written are not rolled back on error. The core stays held, so no partially loaded program ever executes.
- start while busy (LEN_HI..CHECK) is ignored; no restart occurs.
- start and in_valid in the same IDLE cycle: no byte is consumed that cycle, because in_ready is still 0.
- Reset mid-load: async return to IDLE with cpu_hold=1 and any pending wr_en dropped immediately. RAM contents are untouched.
- Datapath widths:
  - Word index and N are 16 bits.
  - The checksum is an 8-bit XOR.

Decomposition:
- Shared package (proc_pkg) holds:
  - The loader state enum.
  - Constants INSTR_W=16 and the frame-field byte order.
  - Opcode constants used by the bench (LDI=3'b101, OUT=3'b100, HALT=3'b011, JUMP=3'b110, SUB=3'b001).
- One sub-module, loader_checksum: the 8-bit XOR accumulator with clear and enable.
- The FSM and address counter stay in the top level.

Test Plan:
- Two-word load:
  - Stimulus: reset, start, then bytes 00 02 A4 0A 60 00 CC back-to-back.
  - Response: wr_en at addr 0 with 0xA40A, then at addr 1 with 0x6000; done=1 and cpu_hold=0 one cycle after 0xCC; error=0.
- Bad checksum:
  - Stimulus: same frame with checksum 0xCD.
  - Response: both writes occur, then error=1, done=0, cpu_hold stays 1.
- Zero and oversize length:
  - Stimulus: 00 00 00.
  - Response: no wr_en, done=1.
  - Stimulus: length 0x0401 with MAX_WORDS=1024.
  - Response: error=1 right after LEN_LO, no writes, and in_ready=0 thereafter.
- Throttled input and ignored start:
  - Stimulus: in_valid toggled randomly during the countdown program (A40A A801 A000 8400 2500 C402 C3FD 8400 6000, N=9), plus a start pulse mid-load.
  - Response: exactly 9 writes to addresses 0..8 with the listed data; the mid-load start is ignored.
- Reset mid-load:
  - Stimulus: assert rst_n=0 between DATA_HI and DATA_LO of word 1.
  - Response: wr_en never fires for word 1; outputs at reset values; a subsequent full load succeeds.

Source files
------------

// File: rtl/proc_pkg.sv
// ============================================================================
// Module : proc_pkg
// Brief  : Shared loader state encoding, frame layout and opcode constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam int INSTR_W = 16;

  // Frame layout: two length bytes (big-endian), then each word high byte first.
  localparam int FRAME_LEN_BYTES = 2;
  localparam bit FRAME_LEN_BIG_ENDIAN = 1'b1;
  localparam bit FRAME_WORD_HI_FIRST = 1'b1;

  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_JUMP = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/loader_checksum.sv
// ============================================================================
// Module : loader_checksum
// Brief  : 8-bit running XOR accumulator with synchronous clear and enable.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'h00;
    end else if (clear) begin
      acc <= 8'h00;
    end else if (en) begin
      acc <= acc ^ data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module : instr_mem_loader
// Brief  : Framed byte-stream loader writing 16-bit words into instruction RAM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
  import proc_pkg::*;
#(
  parameter int          MAX_WORDS = 1024,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [15:0]        wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  loader_state_t state;
  logic [15:0]   len;
  logic [15:0]   idx;
  logic [7:0]    hi_byte;
  logic [7:0]    csum;

  logic          hs;
  logic          start_ok;
  logic [15:0]   len_full;
  logic [15:0]   idx_next;

  assign hs       = in_valid && in_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign len_full = {len[15:8], in_data};
  assign idx_next = idx + 16'd1;

  // The checksum byte itself is never accumulated; it is compared against the running XOR.
  loader_checksum u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_ok),
    .en    (hs && (state != ST_CHECK)),
    .data  (in_data),
    .acc   (csum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      len      <= 16'h0000;
      idx      <= 16'h0000;
      hi_byte  <= 8'h00;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state    <= ST_LEN_HI;
            in_ready <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            idx      <= 16'h0000;
          end
        end
        ST_LEN_HI: begin
          if (hs) begin
            len[15:8] <= in_data;
            state     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (hs) begin
            len <= len_full;
            if (len_full > MAX_N) begin
              state    <= ST_ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else if (len_full == 16'h0000) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (hs) begin
            hi_byte <= in_data;
            state   <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (hs) begin
            wr_en   <= 1'b1;
            wr_data <= {hi_byte, in_data};
            wr_addr <= BASE_ADDR + idx;
            idx     <= idx_next;
            state   <= (idx_next == len) ? ST_CHECK : ST_DATA_HI;
          end
        end
        ST_CHECK: begin
          if (hs) begin
            in_ready <= 1'b0;
            if ((csum ^ in_data) == 8'h00) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module : tb_instr_mem_loader
// Brief  : Directed self-checking bench for instr_mem_loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;
  import proc_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               wr_en;
  logic [15:0]        wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               cpu_hold;
  logic               done;
  logic               error;

  int checks = 0;
  int errors = 0;

  logic [15:0] wa [32];
  logic [15:0] wd [32];
  int          nw = 0;

  instr_mem_loader #(.MAX_WORDS(1024), .BASE_ADDR(16'h0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      if (nw < 32) begin
        wa[nw] = wr_addr;
        wd[nw] = wr_data;
      end
      nw = nw + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; the byte is taken on the rising edge in between.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [7:0]  good2 [7];
  logic [7:0]  prog  [21];
  logic [15:0] exp_prog [9];

  initial begin
    good2 = '{8'h00, 8'h02, 8'hA4, 8'h0A, 8'h60, 8'h00, 8'hCC};
    prog  = '{8'h00, 8'h09, 8'hA4, 8'h0A, 8'hA8, 8'h01, 8'hA0, 8'h00, 8'h84, 8'h00,
              8'h25, 8'h00, 8'hC4, 8'h02, 8'hC3, 8'hFD, 8'h84, 8'h00, 8'h60, 8'h00, 8'h13};
    exp_prog = '{16'hA40A, 16'hA801, 16'hA000, 16'h8400, 16'h2500,
                 16'hC402, 16'hC3FD, 16'h8400, 16'h6000};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wr_en",    {31'd0, wr_en},    32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_error",    {31'd0, error},    32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_wr_addr",  {16'd0, wr_addr},  32'h0000);
    check("rst_wr_data",  {16'd0, wr_data},  32'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // start and in_valid together in IDLE: nothing consumed yet
    in_valid = 1'b1; in_data = 8'h00;
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    check("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);

    // Two-word good load
    nw = 0;
    for (int i = 0; i < 6; i++) send_byte(good2[i]);
    check("t1_done_before", {31'd0, done}, 32'd0);
    send_byte(good2[6]);
    in_valid = 1'b0;
    check("t1_done",     {31'd0, done},     32'd1);
    check("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("t1_error",    {31'd0, error},    32'd0);
    check("t1_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); #1;
    check("t1_nw",  nw, 32'd2);
    check("t1_a0",  {16'd0, wa[0]}, 32'h0000);
    check("t1_d0",  {16'd0, wd[0]}, 32'hA40A);
    check("t1_a1",  {16'd0, wa[1]}, 32'h0001);
    check("t1_d1",  {16'd0, wd[1]}, 32'h6000);
    check("t1_wr_data_hold", {16'd0, wr_data}, 32'h6000);

    // Bad checksum
    @(negedge clk);
    pulse_start();
    check("t2_done_cleared", {31'd0, done},     32'd0);
    check("t2_hold_set",     {31'd0, cpu_hold}, 32'd1);
    nw = 0;
    for (int i = 0; i < 6; i++) send_byte(good2[i]);
    send_byte(8'hCD);
    in_valid = 1'b0;
    check("t2_error",    {31'd0, error},    32'd1);
    check("t2_done",     {31'd0, done},     32'd0);
    check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk); #1;
    check("t2_nw", nw, 32'd2);
    check("t2_d1", {16'd0, wd[1]}, 32'h6000);

    // Zero-length program
    @(negedge clk);
    pulse_start();
    check("t3_error_cleared", {31'd0, error}, 32'd0);
    nw = 0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    in_valid = 1'b0;
    check("t3_done",     {31'd0, done},     32'd1);
    check("t3_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    @(negedge clk); #1;
    check("t3_nw", nw, 32'd0);

    // Oversize length 0x0401
    @(negedge clk);
    pulse_start();
    nw = 0;
    send_byte(8'h04); send_byte(8'h01);
    check("t4_error",    {31'd0, error},    32'd1);
    check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    check("t4_done",     {31'd0, done},     32'd0);
    check("t4_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    in_data = 8'hA4;
    repeat (3) @(negedge clk);
    check("t4_in_ready_late", {31'd0, in_ready}, 32'd0);
    check("t4_nw", nw, 32'd0);
    in_valid = 1'b0;

    // Countdown program with throttled input and an ignored mid-load start
    @(negedge clk);
    pulse_start();
    nw = 0;
    for (int i = 0; i < 21; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 9) begin
        pulse_start();
        check("t5_busy_start_ignored", {31'd0, in_ready}, 32'd1);
      end
      send_byte(prog[i]);
    end
    in_valid = 1'b0;
    check("t5_done",  {31'd0, done},  32'd1);
    check("t5_error", {31'd0, error}, 32'd0);
    @(negedge clk); #1;
    check("t5_nw", nw, 32'd9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t5_addr%0d", k), {16'd0, wa[k]}, k);
      check($sformatf("t5_data%0d", k), {16'd0, wd[k]}, {16'd0, exp_prog[k]});
    end

    // Reset between DATA_HI and DATA_LO of word 1
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(good2[i]);
    in_valid = 1'b0;
    nw = 0;
    rst_n = 1'b0;
    #1;
    check("t6_in_ready", {31'd0, in_ready}, 32'd0);
    check("t6_wr_en",    {31'd0, wr_en},    32'd0);
    check("t6_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("t6_done",     {31'd0, done},     32'd0);
    check("t6_error",    {31'd0, error},    32'd0);
    check("t6_wr_addr",  {16'd0, wr_addr},  32'h0000);
    check("t6_wr_data",  {16'd0, wr_data},  32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t6_no_write", nw, 32'd0);
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(good2[i]);
    in_valid = 1'b0;
    check("t6_reload_done", {31'd0, done},     32'd1);
    check("t6_reload_hold", {31'd0, cpu_hold}, 32'd0);
    @(negedge clk); #1;
    check("t6_reload_nw", nw, 32'd2);
    check("t6_reload_d0", {16'd0, wd[0]}, 32'hA40A);
    check("t6_reload_a1", {16'd0, wa[1]}, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
